ra_stack_ctrl: RTL

- Producer/checker front end for the return-address shadow stack.
- Watches the committed-instruction stream and decodes RISC-V call and return instructions.
- Drives the stack's ena/push/pop/din handshake and samples the stack's mismatch/full/empty flags.
- Raises a sticky control-flow-integrity fault; sits between the writeback/commit stage and the shadow stack.

---
 rtl/ra_stack_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ra_stack_ctrl.sv
// Return-address shadow-stack front end: decodes committed calls/returns,
// queues stack events and drives the stack handshake. Option: RAS_FAULT_HALT_EN.
module ra_stack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int EVQ_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  cm_valid,
  input  logic [31:0]           cm_instr,
  input  logic [DATA_WIDTH-1:0] cm_pc,
  input  logic [DATA_WIDTH-1:0] cm_target,
  output logic                  cm_stall,
  output logic                  stack_ena,
  output logic                  push,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] stack_din,
  input  logic                  stack_mismatch,
  input  logic                  stack_full,
  input  logic                  stack_empty,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  output logic [CNT_WIDTH-1:0]  udf_cnt
);

  localparam int AW = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_FAULT
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic                  r_q_kind [EVQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [EVQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_pc   [EVQ_DEPTH];
  logic [AW-1:0]         r_rd;
  logic [AW-1:0]         r_wr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_tag;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_fault_pc;
  logic [CNT_WIDTH-1:0]  r_ovf;
  logic [CNT_WIDTH-1:0]  r_udf;

  logic [6:0]            w_opc;
  logic [4:0]            w_rdr;
  logic [4:0]            w_rs1;
  logic [2:0]            w_f3;
  logic                  w_jal;
  logic                  w_jalr;
  logic                  w_rd_lnk;
  logic                  w_rs_lnk;
  logic                  w_cor;
  logic                  w_call;
  logic                  w_ret;
  logic                  w_acc;
  logic [1:0]            w_nenq;
  logic                  w_k0;
  logic [DATA_WIDTH-1:0] w_link;
  logic [DATA_WIDTH-1:0] w_d0;
  logic [AW-1:0]         w_wr1;
  logic                  w_deq;
  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         w_drop;
  logic [CW-1:0]         w_cnt_n;
  logic [CW-1:0]         w_free;
  logic                  w_h_kind;
  logic [DATA_WIDTH-1:0] w_h_data;
  logic [DATA_WIDTH-1:0] w_h_pc;
  logic                  w_go;
  logic                  w_ovf_inc;
  logic                  w_udf_inc;
  logic                  w_flt_set;

  assign w_opc    = cm_instr[6:0];
  assign w_rdr    = cm_instr[11:7];
  assign w_f3     = cm_instr[14:12];
  assign w_rs1    = cm_instr[19:15];
  assign w_jal    = (w_opc == 7'b1101111);
  assign w_jalr   = (w_opc == 7'b1100111) && (w_f3 == 3'b000);
  assign w_rd_lnk = (w_rdr == 5'd1) || (w_rdr == 5'd5);
  assign w_rs_lnk = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_cor    = w_jalr && w_rd_lnk && w_rs_lnk && (w_rdr != w_rs1);
  assign w_call   = (w_jal || w_jalr) && w_rd_lnk && !w_cor;
  assign w_ret    = w_jalr && (w_rdr == 5'd0) && w_rs_lnk;

  assign w_acc  = cm_valid && !cm_stall;
  assign w_link = cm_pc + DATA_WIDTH'(4);
  // A coroutine swap pops first so the compare sees the old top
  assign w_k0   = w_ret || w_cor;
  assign w_d0   = w_k0 ? cm_target : w_link;
  assign w_wr1  = r_wr + AW'(1);

  always_comb begin
    w_nenq = 2'd0;
    if (w_acc) begin
      unique case (1'b1)
        w_cor:           w_nenq = 2'd2;
        (w_call | w_ret): w_nenq = 2'd1;
        default:         w_nenq = 2'd0;
      endcase
    end
  end

  assign w_h_kind = r_q_kind[r_rd];
  assign w_h_data = r_q_data[r_rd];
  assign w_h_pc   = r_q_pc[r_rd];

  assign w_deq  = (r_state == S_ISSUE);
  assign w_sum  = SW'(r_cnt) + SW'(w_nenq) - SW'(w_deq);
  // Only reachable after a fault without halt: overwrite the oldest
  assign w_drop = (w_sum > SW'(EVQ_DEPTH)) ? (w_sum - SW'(EVQ_DEPTH)) : '0;
  assign w_cnt_n = (w_sum > SW'(EVQ_DEPTH)) ? CW'(EVQ_DEPTH) : CW'(w_sum);
  assign w_free  = CW'(EVQ_DEPTH) - r_cnt;

`ifdef RAS_FAULT_HALT_EN
  assign cm_stall = (w_free < CW'(2)) || r_fault;
`else
  assign cm_stall = (w_free < CW'(2)) && !r_fault;
`endif

  always_comb begin
    w_state_n = r_state;
    w_go      = 1'b0;
    w_ovf_inc = 1'b0;
    w_udf_inc = 1'b0;
    w_flt_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) w_state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (!w_h_kind && stack_full) begin
          w_ovf_inc = 1'b1;
          w_state_n = S_IDLE;
        end else if (w_h_kind && stack_empty) begin
          w_udf_inc = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_go      = 1'b1;
          w_state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (stack_mismatch) begin
          w_flt_set = 1'b1;
          w_state_n = S_FAULT;
        end else if (r_cnt != '0) begin
          w_state_n = S_ISSUE;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_FAULT: w_state_n = S_FAULT;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_ovf      <= '0;
      r_udf      <= '0;
    end else begin
      r_state <= w_state_n;
      r_rd    <= r_rd + AW'(w_deq) + AW'(w_drop);
      r_wr    <= r_wr + AW'(w_nenq);
      r_cnt   <= w_cnt_n;
      if (w_go) r_tag <= w_h_pc;
      if (w_ovf_inc && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
      if (w_udf_inc && (r_udf != '1)) r_udf <= r_udf + 1'b1;
      if (w_flt_set) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_nenq != 2'd0) begin
      r_q_kind[r_wr] <= w_k0;
      r_q_data[r_wr] <= w_d0;
      r_q_pc[r_wr]   <= cm_pc;
    end
    if (w_nenq == 2'd2) begin
      r_q_kind[w_wr1] <= 1'b0;
      r_q_data[w_wr1] <= w_link;
      r_q_pc[w_wr1]   <= cm_pc;
    end
  end

  assign stack_ena = w_go && !Rst;
  assign push      = stack_ena && !w_h_kind;
  assign pop       = stack_ena && w_h_kind;
  assign stack_din = stack_ena ? w_h_data : '0;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;
  assign ovf_cnt   = r_ovf;
  assign udf_cnt   = r_udf;

endmodule
